fifo_out_sync_tuser_pkt: RTL and testbench
==========================================

FIFO_OUT_SYNC_TUSER_PKT -- requirements
Module: fifo_out_sync_tuser_pkt

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: TDATA width, multiple of 8, minimum 8.
REQ-002 SHALL have parameter USER_WIDTH, default 1: TUSER width, minimum 1.
REQ-003 SHALL have parameter DEPTH, default 64: storage words, power of two, 4..4096.
REQ-004 SHALL have parameter MEMTYPE, default "block": RAM style ("block"/"distributed"), passed to the RAM as a synthesis attribute.
REQ-005 SHALL have parameter AWFULL_GAP, default 4: OUT_AWFULL asserts when free space is at most this value.
REQ-006 Ports: CLK in 1 clock; RESETN in 1 asynchronous active-low reset.
REQ-007 Ports: OUT_DIN_DATA in DATA_WIDTH; OUT_DIN_KEEP in DATA_WIDTH/8; OUT_DIN_USER in USER_WIDTH; OUT_DIN_LAST in 1; OUT_WREN in 1 write request.
REQ-008 Ports: OUT_FULL out 1; OUT_AWFULL out 1; OUT_OVERFLOW out 1 one-cycle pulse on a dropped write; OUT_COUNT out $clog2(DEPTH)+1 words held.
REQ-009 Ports: M_AXIS_TDATA/TKEEP/TUSER/TLAST out, same widths as inputs; M_AXIS_TVALID out 1; M_AXIS_TREADY in 1.

Function
REQ-010 Write accepted on a rising CLK when OUT_WREN=1 and OUT_FULL=1 is not registered at that edge; the {LAST,USER,KEEP,DATA} word is stored in order.
REQ-011 OUT_WREN=1 while OUT_FULL=1 SHALL drop the word, leave state unchanged and pulse OUT_OVERFLOW for one cycle.
REQ-012 Read side SHALL be first-word-fall-through: a RAM stage with registered read feeds an output register; the beat transfers when TVALID=1 and TREADY=1.
REQ-013 A word accepted at edge N into an empty FIFO SHALL show TVALID=1 after edge N+2; with TREADY held at 1 and writes every cycle, throughput SHALL be one beat per cycle.
REQ-014 While TVALID=1 and TREADY=0, all M_AXIS outputs SHALL be stable.
REQ-015 OUT_COUNT SHALL include words in the RAM, in the read pipeline and in the output register; simultaneous accept and transfer leave it unchanged.
REQ-016 OUT_FULL = (OUT_COUNT == DEPTH); OUT_AWFULL = (DEPTH - OUT_COUNT <= AWFULL_GAP); both registered, updated on the edge the count changes.
REQ-017 Pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0 without a gap cycle.
REQ-018 A write while full and a transfer in the same cycle: the write is dropped, per REQ-011; the freed slot is usable from the next cycle.

Reset
REQ-019 RESETN=0 SHALL asynchronously clear pointers, OUT_COUNT, the packet counter and the output-valid flag; deassertion is synchronised internally to CLK (2 flops).
REQ-020 Reset values: TVALID=0, TDATA/TKEEP/TUSER/TLAST=0, OUT_FULL=0, OUT_AWFULL=0, OUT_OVERFLOW=0, OUT_COUNT=0.
REQ-021 Reset mid-packet SHALL discard all stored data; the first write after release starts a fresh packet.

Configuration
REQ-022 Macro FIFO_OUT_PKT_MODE_EN SHALL select store-and-forward mode.
REQ-023 When it is defined, a packet counter counts stored TLAST words. The first beat of a packet SHALL NOT present TVALID until that packet's TLAST word is accepted; after that, the packet streams without bubbles while TREADY=1.
REQ-024 When it is defined and OUT_FULL=1 with the packet counter at 0 (packet longer than DEPTH), the block SHALL release the packet in cut-through mode until its TLAST is read.
REQ-025 When it is undefined, the block SHALL operate in pure cut-through mode per REQ-013 and the packet counter logic SHALL be absent.

Structure
REQ-026 Package fifo_out_pkg SHALL hold the word typedef builder (last/user/keep/data field offsets) and the constant CDC_SYNC_STAGES=2.
REQ-027 The storage SHALL be sub-module fifo_out_ram: simple dual-port, one write port, one registered read port, honouring MEMTYPE.

Verification
REQ-028 Reset, then write 0x11,0x22,0x33 with TREADY=1 -> TVALID rises 2 cycles after the first write; beats arrive in order 0x11,0x22,0x33; OUT_COUNT returns to 0.
REQ-029 DEPTH=64, TREADY=0, 65 writes -> OUT_FULL=1 after the 64th; the 65th is dropped and OUT_OVERFLOW pulses once; OUT_AWFULL=1 from count 60.
REQ-030 Full FIFO, TREADY=1 and OUT_WREN=1 in the same cycle -> the write is dropped and OUT_COUNT=63; a write on the next cycle is accepted.
REQ-031 Packet mode on, 5-beat packet written with a 10-cycle gap before TLAST -> TVALID stays 0 until TLAST is stored, then 5 contiguous beats.
REQ-032 Packet mode on, 70-beat packet with DEPTH=64 -> cut-through release, all 70 beats are delivered in order, no deadlock.
REQ-033 RESETN pulsed low mid-packet -> outputs clear immediately (asynchronous); the next packet is delivered intact.

Source files
------------

// File: rtl/fifo_out_pkg.sv
// Shared constants and word-layout helpers for the AXI-Stream output FIFO.
// A stored word is packed as {last, user, keep, data}, data in the LSBs.
package fifo_out_pkg;

  localparam int CDC_SYNC_STAGES = 2;

  function automatic int keep_lsb(input int dw);
    return dw;
  endfunction

  function automatic int user_lsb(input int dw);
    return dw + dw / 8;
  endfunction

  function automatic int last_bit(input int dw, input int uw);
    return dw + dw / 8 + uw;
  endfunction

  function automatic int word_width(input int dw, input int uw);
    return last_bit(dw, uw) + 1;
  endfunction

endpackage

// File: rtl/fifo_out_ram.sv
// Simple dual-port storage: one write port, one registered read port.
// The read register holds its value while i_rd_en is low.
module fifo_out_ram #(
  parameter int    WIDTH   = 38,
  parameter int    DEPTH   = 64,
  parameter string MEMTYPE = "block",
  parameter int    AW      = $clog2(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_rd_data;

  generate
    if (MEMTYPE == "distributed") begin : g_dist
      (* ram_style = "distributed" *) logic [WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
      end
    end else begin : g_block
      (* ram_style = "block" *) logic [WIDTH-1:0] r_mem [DEPTH];
      always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
      end
    end
  endgenerate

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/fifo_out_sync_tuser_pkt.sv
// Synchronous FWFT FIFO feeding an AXI-Stream master (RAM -> read reg -> output reg).
// Define FIFO_OUT_PKT_MODE_EN for store-and-forward packet mode with cut-through fallback.
module fifo_out_sync_tuser_pkt #(
  parameter int    DATA_WIDTH = 32,
  parameter int    USER_WIDTH = 1,
  parameter int    DEPTH      = 64,
  parameter string MEMTYPE    = "block",
  parameter int    AWFULL_GAP = 4
) (
  input  logic                      CLK,
  input  logic                      RESETN,
  input  logic [DATA_WIDTH-1:0]     OUT_DIN_DATA,
  input  logic [DATA_WIDTH/8-1:0]   OUT_DIN_KEEP,
  input  logic [USER_WIDTH-1:0]     OUT_DIN_USER,
  input  logic                      OUT_DIN_LAST,
  input  logic                      OUT_WREN,
  output logic                      OUT_FULL,
  output logic                      OUT_AWFULL,
  output logic                      OUT_OVERFLOW,
  output logic [$clog2(DEPTH):0]    OUT_COUNT,
  output logic [DATA_WIDTH-1:0]     M_AXIS_TDATA,
  output logic [DATA_WIDTH/8-1:0]   M_AXIS_TKEEP,
  output logic [USER_WIDTH-1:0]     M_AXIS_TUSER,
  output logic                      M_AXIS_TLAST,
  output logic                      M_AXIS_TVALID,
  input  logic                      M_AXIS_TREADY
);

  import fifo_out_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int KW = DATA_WIDTH / 8;
  localparam int WW = word_width(DATA_WIDTH, USER_WIDTH);
  localparam int KEEP_LSB = keep_lsb(DATA_WIDTH);
  localparam int USER_LSB = user_lsb(DATA_WIDTH);
  localparam int LAST_BIT = last_bit(DATA_WIDTH, USER_WIDTH);

  logic [CDC_SYNC_STAGES-1:0] r_rst_sync;
  logic                       w_rst_n;

  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]           r_count, r_ram_cnt;
  logic [CW-1:0]           w_cnt_nxt, w_ram_cnt_nxt;
  logic                    r_full, r_awfull, r_ovf;
  logic                    r_rd_vld;
  logic                    r_out_vld;
  logic [DATA_WIDTH-1:0]   r_out_data;
  logic [KW-1:0]           r_out_keep;
  logic [USER_WIDTH-1:0]   r_out_user;
  logic                    r_out_last;

  logic [WW-1:0]           w_wr_word, w_rd_word;
  logic                    w_wr_acc, w_xfer, w_release;
  logic                    w_out_take, w_s1_move, w_ram_rd;

  // Assert immediately, release only after CDC_SYNC_STAGES clean clock edges.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) r_rst_sync <= '0;
    else         r_rst_sync <= {r_rst_sync[CDC_SYNC_STAGES-2:0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[CDC_SYNC_STAGES-1];

  assign w_wr_word  = {OUT_DIN_LAST, OUT_DIN_USER, OUT_DIN_KEEP, OUT_DIN_DATA};
  assign w_wr_acc   = OUT_WREN & ~r_full;
  assign w_xfer     = M_AXIS_TVALID & M_AXIS_TREADY;
  assign w_out_take = ~r_out_vld | w_xfer;
  assign w_s1_move  = r_rd_vld & w_out_take;
  assign w_ram_rd   = (r_ram_cnt != '0) & (~r_rd_vld | w_s1_move);

  fifo_out_ram #(
    .WIDTH   (WW),
    .DEPTH   (DEPTH),
    .MEMTYPE (MEMTYPE),
    .AW      (AW)
  ) u_ram (
    .i_clk     (CLK),
    .i_wr_en   (w_wr_acc),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (w_wr_word),
    .i_rd_en   (w_ram_rd),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_word)
  );

  always_comb begin
    w_cnt_nxt = r_count;
    if (w_wr_acc && !w_xfer)      w_cnt_nxt = r_count + CW'(1);
    else if (!w_wr_acc && w_xfer) w_cnt_nxt = r_count - CW'(1);

    w_ram_cnt_nxt = r_ram_cnt;
    if (w_wr_acc && !w_ram_rd)      w_ram_cnt_nxt = r_ram_cnt + CW'(1);
    else if (!w_wr_acc && w_ram_rd) w_ram_cnt_nxt = r_ram_cnt - CW'(1);
  end

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ram_cnt  <= '0;
      r_full     <= 1'b0;
      r_awfull   <= 1'b0;
      r_ovf      <= 1'b0;
      r_rd_vld   <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_data <= '0;
      r_out_keep <= '0;
      r_out_user <= '0;
      r_out_last <= 1'b0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_ram_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count   <= w_cnt_nxt;
      r_ram_cnt <= w_ram_cnt_nxt;
      r_full    <= (w_cnt_nxt == CW'(DEPTH));
      r_awfull  <= ((CW'(DEPTH) - w_cnt_nxt) <= CW'(AWFULL_GAP));
      r_ovf     <= OUT_WREN & r_full;
      r_rd_vld  <= w_ram_rd | (r_rd_vld & ~w_s1_move);
      r_out_vld <= w_s1_move | (r_out_vld & ~w_xfer);
      if (w_s1_move) begin
        r_out_data <= w_rd_word[DATA_WIDTH-1:0];
        r_out_keep <= w_rd_word[KEEP_LSB +: KW];
        r_out_user <= w_rd_word[USER_LSB +: USER_WIDTH];
        r_out_last <= w_rd_word[LAST_BIT];
      end
    end
  end

`ifdef FIFO_OUT_PKT_MODE_EN
  // r_pkt_cnt: complete packets held anywhere in the FIFO; r_cut: head packet
  // is larger than the FIFO and streams out before its TLAST arrives.
  logic [CW-1:0] r_pkt_cnt;
  logic          r_cut;
  logic          w_pkt_inc, w_pkt_dec;

  assign w_pkt_inc = w_wr_acc & OUT_DIN_LAST;
  assign w_pkt_dec = w_xfer & r_out_last;

  always_ff @(posedge CLK or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pkt_cnt <= '0;
      r_cut     <= 1'b0;
    end else begin
      if (w_pkt_inc && !w_pkt_dec)      r_pkt_cnt <= r_pkt_cnt + CW'(1);
      else if (!w_pkt_inc && w_pkt_dec) r_pkt_cnt <= r_pkt_cnt - CW'(1);
      if (w_pkt_dec)                             r_cut <= 1'b0;
      else if (r_full && (r_pkt_cnt == '0))      r_cut <= 1'b1;
    end
  end

  assign w_release = (r_pkt_cnt != '0) | r_cut;
`else
  assign w_release = 1'b1;
`endif

  assign M_AXIS_TVALID = r_out_vld & w_release;
  assign M_AXIS_TDATA  = r_out_data;
  assign M_AXIS_TKEEP  = r_out_keep;
  assign M_AXIS_TUSER  = r_out_user;
  assign M_AXIS_TLAST  = r_out_last;
  assign OUT_FULL      = r_full;
  assign OUT_AWFULL    = r_awfull;
  assign OUT_OVERFLOW  = r_ovf;
  assign OUT_COUNT     = r_count;

endmodule

// File: tb/tb_fifo_out_sync_tuser_pkt.sv
// Directed bench for fifo_out_sync_tuser_pkt with a queue scoreboard on the AXI-Stream side.
// Packet-mode steps follow FIFO_OUT_PKT_MODE_EN, matching the build of the DUT.
module tb_fifo_out_sync_tuser_pkt;

  localparam int DW = 32;
  localparam int UW = 1;
  localparam int DEPTH = 64;
  localparam int KW = DW / 8;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = 1 + UW + KW + DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] din_data = '0;
  logic [KW-1:0] din_keep = '0;
  logic [UW-1:0] din_user = '0;
  logic          din_last = 1'b0;
  logic          wren = 1'b0;
  logic          full, awfull, ovf;
  logic [CW-1:0] count;
  logic [DW-1:0] tdata;
  logic [KW-1:0] tkeep;
  logic [UW-1:0] tuser;
  logic          tlast, tvalid;
  logic          tready = 1'b0;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int rx0;
  logic [WW-1:0] exp_q[$];
  logic [WW-1:0] exp_w;
  logic [WW-1:0] prev_word;
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b0;

  fifo_out_sync_tuser_pkt #(
    .DATA_WIDTH (DW),
    .USER_WIDTH (UW),
    .DEPTH      (DEPTH),
    .MEMTYPE    ("block"),
    .AWFULL_GAP (4)
  ) dut (
    .CLK           (clk),
    .RESETN        (rst_n),
    .OUT_DIN_DATA  (din_data),
    .OUT_DIN_KEEP  (din_keep),
    .OUT_DIN_USER  (din_user),
    .OUT_DIN_LAST  (din_last),
    .OUT_WREN      (wren),
    .OUT_FULL      (full),
    .OUT_AWFULL    (awfull),
    .OUT_OVERFLOW  (ovf),
    .OUT_COUNT     (count),
    .M_AXIS_TDATA  (tdata),
    .M_AXIS_TKEEP  (tkeep),
    .M_AXIS_TUSER  (tuser),
    .M_AXIS_TLAST  (tlast),
    .M_AXIS_TVALID (tvalid),
    .M_AXIS_TREADY (tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one write for the next edge; the model keeps it only if the FIFO is not full.
  task automatic wr(input logic [31:0] d, input logic l);
    din_data = d;
    din_keep = d[3:0];
    din_user = d[4];
    din_last = l;
    wren     = 1'b1;
    if (!full) exp_q.push_back({l, d[4], d[3:0], d});
    tick();
    wren     = 1'b0;
    din_last = 1'b0;
  endtask

  task automatic wr_wait(input logic [31:0] d, input logic l);
    int n = 0;
    while (full && n < 300) begin
      tick();
      n++;
    end
    wr(d, l);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (count != '0 && n < 1000) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_queue"}, 64'(exp_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n && tvalid && tready) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL beat_unexpected observed=0x%0h expected=none", {tlast, tuser, tkeep, tdata});
      end
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        chk("beat", 64'({tlast, tuser, tkeep, tdata}), 64'(exp_w));
      end
      rx_cnt++;
    end
    if (rst_n && prev_rst && prev_v && !prev_r)
      chk("stable", 64'({tvalid, tlast, tuser, tkeep, tdata}), 64'({1'b1, prev_word}));
    prev_word = {tlast, tuser, tkeep, tdata};
    prev_v    = tvalid;
    prev_r    = tready;
    prev_rst  = rst_n;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values
    repeat (3) tick();
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tdata",  64'(tdata),  64'd0);
    chk("rst_tkeep",  64'(tkeep),  64'd0);
    chk("rst_tuser",  64'(tuser),  64'd0);
    chk("rst_tlast",  64'(tlast),  64'd0);
    chk("rst_full",   64'(full),   64'd0);
    chk("rst_awfull", 64'(awfull), 64'd0);
    chk("rst_ovf",    64'(ovf),    64'd0);
    chk("rst_count",  64'(count),  64'd0);
    rst_n = 1'b1;
    repeat (3) tick();

    // Three-word stream, TVALID two edges after first accept
    tready = 1'b1;
    rx0 = rx_cnt;
    wr(32'h11, 1'b0);
    chk("lat_edge0", 64'(tvalid), 64'd0);
    wr(32'h22, 1'b0);
    chk("lat_edge1", 64'(tvalid), 64'd0);
    wr(32'h33, 1'b1);
    chk("lat_edge2", 64'(tvalid), 64'd1);
    drain("drain_small");
    chk("rx_small", 64'(rx_cnt - rx0), 64'd3);

    // Fill to full with TREADY low, then one dropped write
    tready = 1'b0;
    rx0 = rx_cnt;
    for (int i = 0; i < 65; i++) begin
      wr(32'h1000 + i, (i == 63));
      if (i == 58) begin
        chk("awfull_59", 64'(awfull), 64'd0);
        chk("count_59",  64'(count),  64'd59);
      end
      if (i == 59) chk("awfull_60", 64'(awfull), 64'd1);
      if (i == 62) chk("full_63",   64'(full),   64'd0);
      if (i == 63) begin
        chk("full_64",    64'(full),  64'd1);
        chk("count_64",   64'(count), 64'd64);
        chk("ovf_before", 64'(ovf),   64'd0);
      end
      if (i == 64) begin
        chk("ovf_pulse",  64'(ovf),   64'd1);
        chk("count_drop", 64'(count), 64'd64);
      end
    end
    tick();
    chk("ovf_clear", 64'(ovf), 64'd0);

    // Write while full with a transfer in the same cycle
    tready = 1'b1;
    wr(32'hBAD, 1'b0);
    chk("same_cyc_count", 64'(count), 64'd63);
    chk("same_cyc_ovf",   64'(ovf),   64'd1);
    chk("same_cyc_full",  64'(full),  64'd0);
    tready = 1'b0;
    wr(32'h2000, 1'b1);
    chk("after_count", 64'(count), 64'd64);
    chk("after_full",  64'(full),  64'd1);
    tready = 1'b1;
    drain("drain_full");
    chk("rx_full", 64'(rx_cnt - rx0), 64'd65);

`ifdef FIFO_OUT_PKT_MODE_EN
    // Store-and-forward: held until TLAST, then contiguous
    rx0 = rx_cnt;
    for (int i = 0; i < 4; i++) wr(32'h500 + i, 1'b0);
    for (int k = 0; k < 10; k++) begin
      chk("pkt_hold", 64'(tvalid), 64'd0);
      tick();
    end
    wr(32'h504, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk("pkt_stream", 64'(tvalid), 64'd1);
      tick();
    end
    chk("pkt_done", 64'(tvalid), 64'd0);
    chk("rx_pkt", 64'(rx_cnt - rx0), 64'd5);

    // Packet longer than the FIFO falls back to cut-through
    rx0 = rx_cnt;
    for (int i = 0; i < 70; i++) wr_wait(32'h600 + i, (i == 69));
    drain("drain_long");
    chk("rx_long", 64'(rx_cnt - rx0), 64'd70);
`else
    // Cut-through latency without TLAST
    rx0 = rx_cnt;
    wr(32'h300, 1'b0);
    chk("ct_lat0", 64'(tvalid), 64'd0);
    wr(32'h301, 1'b0);
    chk("ct_lat1", 64'(tvalid), 64'd0);
    tick();
    chk("ct_lat2", 64'(tvalid), 64'd1);
    wr(32'h302, 1'b1);
    drain("drain_ct");
    chk("rx_ct", 64'(rx_cnt - rx0), 64'd3);
`endif

    // Asynchronous reset mid-packet
    tready = 1'b0;
    wr(32'h701, 1'b0);
    wr(32'h702, 1'b0);
    wr(32'h703, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", 64'(tvalid), 64'd0);
    chk("arst_tdata",  64'(tdata),  64'd0);
    chk("arst_count",  64'(count),  64'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    tready = 1'b1;
    rx0 = rx_cnt;
    for (int i = 0; i < 4; i++) wr(32'hA0 + i, (i == 3));
    drain("drain_post_rst");
    chk("rx_post_rst", 64'(rx_cnt - rx0), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
